convergencia_ctrl: RTL
======================

Name: convergencia_ctrl

Overview:
- Training sequencer that sits directly upstream of the perceptron epoch engine.
- Loads initial weights, launches one epoch at a time and feeds each epoch's output weights back as the next epoch's input weights.
- After every epoch, compares the engine's per-sample results against the targets. Stops on convergence or on an epoch limit.
- Presents final weights, epoch count and convergence status. All data are IEEE-754 half precision (1.0 = 0x3C00).

Parameters:
- TAM, 16, data word width in bits (fp16).
- N_AMOSTRAS, 4, number of training samples per epoch.
- MAX_EPOCAS, 32, epoch limit (1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin training; sampled only in IDLE.
- w0_init, w1_init, w2_init  input  TAM each  initial weights.
- d  input  N_AMOSTRAS*TAM  target outputs; sample k occupies bits [k*TAM +: TAM].
- ep_start  output  1  one-cycle pulse launching an epoch.
- ep_w0, ep_w1, ep_w2  output  TAM each  weights presented to the engine; stable from ep_start until ep_done.
- ep_done  input  1  one-cycle pulse from the engine marking epoch completion.
- ep_w0_out, ep_w1_out, ep_w2_out  input  TAM each  updated weights; valid with ep_done.
- ep_result  input  N_AMOSTRAS*TAM  per-sample results; valid with ep_done.
- w0, w1, w2  output  TAM each  final weights.
- epocas  output  8  epochs completed.
- busy  output  1  high from LOAD through CHECK.
- done  output  1  training finished; held until the next accepted start.
- converged  output  1  valid while done is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - ep_w*, w*, epocas, busy, done, converged and ep_start all clear to 0.
  - Reset asserted mid-epoch aborts immediately; a late ep_done after reset is ignored.
- IDLE:
  - start=1 moves to LOAD. done and converged clear, epocas clears to 0.
  - start=0 stays in IDLE.
- LOAD (1 cycle): ep_w0..2 <= w0_init..2; next state RUN.
- RUN (1 cycle): ep_start=1; next state WAIT. ep_start is registered and is high only in RUN.
- WAIT:
  - Holds until ep_done=1.
  - On that edge: ep_w0..2 <= ep_w*_out; result vector latched internally; epocas increments (saturating at 255); next state CHECK.
  - ep_done outside WAIT is ignored.
- CHECK (1 cycle): match = every sample k has latched result[k] equal to d[k].
  - Equality is bitwise, except 0x0000 and 0x8000 are treated as equal.
  - match=1: go to FINISH with converged=1.
  - Else if epocas == MAX_EPOCAS: go to FINISH with converged=0.
  - Else: go to RUN (next epoch uses the fed-back weights).
- FINISH (1 cycle):
  - w0..2 <= ep_w0..2; done=1; busy=0; next state IDLE.
  - done and converged remain held in IDLE.
- start while busy is ignored. A start in the FINISH cycle is ignored; start is first sampled in the following IDLE cycle.
- Minimum latency from start to done: 4 cycles + the engine's epoch latency per epoch, + 2 cycles per additional epoch (CHECK→RUN).
- No arithmetic is done here; weights pass through unmodified.

Test Plan:
1. Converge on first epoch:
   - Stimulus: init weights 0x0000; d = {0,0x3C00,0x3C00,0x3C00}; stub engine returns the same vector and weights 0x3800/0x3C00/0x3C00 after 5 cycles.
   - Required: exactly one ep_start; done=1, converged=1, epocas=1, w = 0x3800/0x3C00/0x3C00.
2. Converge on third epoch:
   - Stimulus: stub returns mismatching results for epochs 1 and 2, matching on epoch 3, with weights incrementing each epoch.
   - Required: three ep_start pulses; ep_w on each launch equals the previous epoch's ep_w*_out; epocas=3; converged=1.
3. Limit reached:
   - Stimulus: MAX_EPOCAS=4; stub never matches.
   - Required: four ep_start pulses; done=1, converged=0, epocas=4; final w = epoch-4 outputs.
4. Signed-zero equivalence:
   - Stimulus: d[0]=0x0000, stub result[0]=0x8000, other samples match.
   - Required: converged=1 after epoch 1.
5. Reset and spurious inputs:
   - Stimulus: assert reset=0 during WAIT of epoch 2, then pulse ep_done; separately pulse ep_done while in IDLE.
   - Required: all outputs 0 immediately on reset; state IDLE; no ep_start; epocas stays 0.
6. start while busy / restart:
   - Stimulus: pulse start during WAIT.
   - Required: no effect. After done, a new start clears done and converged and reloads the w*_init values.

Source files
------------

// File: rtl/convergencia_ctrl.sv
// convergencia_ctrl: training sequencer for the perceptron epoch engine.
// Loads the initial weights and launches one epoch at a time. Each epoch's
// output weights become the next epoch's input weights. After every epoch the
// per-sample results are compared with the targets. Training stops when they
// all match (converged) or when the epoch limit is reached. Weights pass
// through this block unmodified.
module convergencia_ctrl #(
  parameter int TAM        = 16,
  parameter int N_AMOSTRAS = 4,
  parameter int MAX_EPOCAS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [TAM-1:0]            w0_init,
  input  logic [TAM-1:0]            w1_init,
  input  logic [TAM-1:0]            w2_init,
  input  logic [N_AMOSTRAS*TAM-1:0] d,
  output logic                      ep_start,
  output logic [TAM-1:0]            ep_w0,
  output logic [TAM-1:0]            ep_w1,
  output logic [TAM-1:0]            ep_w2,
  input  logic                      ep_done,
  input  logic [TAM-1:0]            ep_w0_out,
  input  logic [TAM-1:0]            ep_w1_out,
  input  logic [TAM-1:0]            ep_w2_out,
  input  logic [N_AMOSTRAS*TAM-1:0] ep_result,
  output logic [TAM-1:0]            w0,
  output logic [TAM-1:0]            w1,
  output logic [TAM-1:0]            w2,
  output logic [7:0]                epocas,
  output logic                      busy,
  output logic                      done,
  output logic                      converged
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [7:0] EPOCH_LIMIT = 8'(MAX_EPOCAS);

  state_t                      state_q, state_d;
  logic [TAM-1:0]              ep_w0_q, ep_w0_d;
  logic [TAM-1:0]              ep_w1_q, ep_w1_d;
  logic [TAM-1:0]              ep_w2_q, ep_w2_d;
  logic [TAM-1:0]              w0_q, w0_d;
  logic [TAM-1:0]              w1_q, w1_d;
  logic [TAM-1:0]              w2_q, w2_d;
  logic [7:0]                  epocas_q, epocas_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        converged_q, converged_d;
  logic                        ep_start_q, ep_start_d;
  logic [N_AMOSTRAS*TAM-1:0]   result_q, result_d;

  logic [N_AMOSTRAS-1:0]       sample_eq;
  logic                        match;

  // Per-sample compare. Results are bit-exact, except +0 and -0, which count
  // as equal. Both words must have all bits below the sign bit clear.
  generate
    for (genvar gi = 0; gi < N_AMOSTRAS; gi++) begin : g_cmp
      logic [TAM-1:0] r_w, t_w;
      assign r_w = result_q[gi*TAM +: TAM];
      assign t_w = d[gi*TAM +: TAM];
      assign sample_eq[gi] = (r_w == t_w) ||
                             ((r_w[TAM-2:0] == '0) && (t_w[TAM-2:0] == '0));
    end
  endgenerate

  assign match = &sample_eq;

  // Next-state logic and register updates for the training sequence.
  always_comb begin
    state_d     = state_q;
    ep_w0_d     = ep_w0_q;
    ep_w1_d     = ep_w1_q;
    ep_w2_d     = ep_w2_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    epocas_d    = epocas_q;
    busy_d      = busy_q;
    done_d      = done_q;
    converged_d = converged_q;
    result_d    = result_q;
    ep_start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          done_d      = 1'b0;
          converged_d = 1'b0;
          epocas_d    = 8'd0;
          busy_d      = 1'b1;
        end
      end
      S_LOAD: begin
        ep_w0_d    = w0_init;
        ep_w1_d    = w1_init;
        ep_w2_d    = w2_init;
        state_d    = S_RUN;
        ep_start_d = 1'b1;  // registered, so the pulse appears exactly in RUN
      end
      S_RUN: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ep_done) begin
          ep_w0_d  = ep_w0_out;
          ep_w1_d  = ep_w1_out;
          ep_w2_d  = ep_w2_out;
          result_d = ep_result;
          if (epocas_q != 8'hFF) begin
            epocas_d = epocas_q + 8'd1;
          end
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (match) begin
          state_d     = S_FINISH;
          converged_d = 1'b1;
          busy_d      = 1'b0;
        end else if (epocas_q == EPOCH_LIMIT) begin
          state_d     = S_FINISH;
          converged_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          state_d    = S_RUN;
          ep_start_d = 1'b1;
        end
      end
      S_FINISH: begin
        w0_d    = ep_w0_q;
        w1_d    = ep_w1_q;
        w2_d    = ep_w2_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any epoch in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ep_w0_q     <= '0;
      ep_w1_q     <= '0;
      ep_w2_q     <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      epocas_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      ep_start_q  <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      ep_w0_q     <= ep_w0_d;
      ep_w1_q     <= ep_w1_d;
      ep_w2_q     <= ep_w2_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      epocas_q    <= epocas_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      converged_q <= converged_d;
      ep_start_q  <= ep_start_d;
      result_q    <= result_d;
    end
  end

  assign ep_start  = ep_start_q;
  assign ep_w0     = ep_w0_q;
  assign ep_w1     = ep_w1_q;
  assign ep_w2     = ep_w2_q;
  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign epocas    = epocas_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;

endmodule
